// File: rtl/ro_race_counter_pkg.sv
// ============================================================================
// Module   : puf_cnt_pkg
// Purpose  : Shared state and mode encodings for the RO race counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package puf_cnt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        COUNT = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } rc_state_t;

    typedef enum logic {
        MODE_RACE   = 1'b0,
        MODE_WINDOW = 1'b1
    } rc_mode_t;

endpackage

`default_nettype wire

// File: rtl/ro_edge_sync.sv
// ============================================================================
// Module   : ro_edge_sync
// Purpose  : Two-flop synchroniser for one RO tap plus a rising-edge pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ro_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic ro_in,
    output logic edge_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= ro_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign edge_pulse = r_sync2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/ro_race_counter.sv
// ============================================================================
// Module   : ro_race_counter
// Purpose  : Counts edges on NUM_CH RO taps in race or window mode and
//            reports the winning channel as one PUF response symbol.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ro_race_counter
    import puf_cnt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int N      = 23,
    parameter int WIN_W  = 24,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_CH-1:0]     ro_in,
    input  logic                  start,
    input  logic                  mode,
    input  logic [WIN_W-1:0]      window,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic [CH_W-1:0]       winner,
    output logic                  tie,
    output logic                  timeout,
    output logic [NUM_CH*N-1:0]   counts
);

    localparam logic [N-1:0]     c_sat     = '1;
    localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);

    rc_state_t                   r_state;
    rc_state_t                   w_state_nxt;
    rc_mode_t                    r_mode;
    logic [WIN_W-1:0]            r_win_len;
    logic [WIN_W-1:0]            r_win;
    logic [NUM_CH-1:0][N-1:0]    r_cnt;
    logic [NUM_CH-1:0][N-1:0]    w_cnt_nxt;
    logic [NUM_CH-1:0]           w_edge;
    logic                        w_goal;
    logic                        w_expire;
    logic [N-1:0]                w_max;
    logic [CH_W-1:0]             w_arg_idx;
    logic                        w_arg_tie;
    logic                        w_seen;
    logic                        r_busy;
    logic                        r_done;
    logic [CH_W-1:0]             r_winner;
    logic                        r_tie;
    logic                        r_timeout;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        ro_edge_sync u_sync (
            .clk        (clk),
            .reset_n    (reset_n),
            .ro_in      (ro_in[g]),
            .edge_pulse (w_edge[g])
        );
    end

    // Saturating increments; the goal is judged on the post-increment value so
    // every channel freezes in the same cycle the first one crosses.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_goal    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_edge[i] && (r_cnt[i] != c_sat)) begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end
            if (w_cnt_nxt[i][N-1]) begin
                w_goal = 1'b1;
            end
        end
        w_goal   = w_goal && (r_mode == MODE_RACE);
        w_expire = (r_win == c_win_one);
    end

    // Linear argmax: strict '>' keeps the lowest index on equal counts.
    always_comb begin
        w_max     = r_cnt[0];
        w_arg_idx = '0;
        w_arg_tie = 1'b0;
        w_seen    = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            if (r_cnt[i] > w_max) begin
                w_max     = r_cnt[i];
                w_arg_idx = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_cnt[i] == w_max) begin
                if (w_seen) begin
                    w_arg_tie = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = ARM;
            ARM:     w_state_nxt = COUNT;
            COUNT:   if (w_goal || w_expire) w_state_nxt = EVAL;
            EVAL:    w_state_nxt = DONE;
            DONE:    if (ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode    <= MODE_RACE;
            r_win_len <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_winner  <= '0;
            r_tie     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode    <= rc_mode_t'(mode);
                        r_win_len <= window;
                    end
                end
                ARM: begin
                    r_cnt     <= '0;
                    r_win     <= (r_win_len == '0) ? c_win_one : r_win_len;
                    r_winner  <= '0;
                    r_tie     <= 1'b0;
                    r_timeout <= 1'b0;
                end
                COUNT: begin
                    r_cnt <= w_cnt_nxt;
                    r_win <= r_win - c_win_one;
                    if (w_expire && !w_goal && (r_mode == MODE_RACE)) begin
                        r_timeout <= 1'b1;
                    end
                end
                EVAL: begin
                    r_winner <= w_arg_idx;
                    r_tie    <= w_arg_tie;
                end
                DONE: begin
                    if (ack) begin
                        r_tie     <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
            r_busy <= (w_state_nxt == ARM) || (w_state_nxt == COUNT) || (w_state_nxt == EVAL);
            r_done <= (w_state_nxt == DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign winner  = r_winner;
    assign tie     = r_tie;
    assign timeout = r_timeout;
    assign counts  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ro_race_counter.sv
// ============================================================================
// Module   : tb_ro_race_counter
// Purpose  : Directed bench for ro_race_counter (NUM_CH=4, N=6, goal=32).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ro_race_counter;

    localparam int NUM_CH = 4;
    localparam int N      = 6;
    localparam int WIN_W  = 24;
    localparam int CH_W   = 2;

    logic                  clk     = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NUM_CH-1:0]     ro_in   = '0;
    logic                  start   = 1'b0;
    logic                  mode    = 1'b0;
    logic [WIN_W-1:0]      window  = '0;
    logic                  ack     = 1'b0;
    logic                  busy;
    logic                  done;
    logic [CH_W-1:0]       winner;
    logic                  tie;
    logic                  timeout;
    logic [NUM_CH*N-1:0]   counts;

    int vectors = 0;
    int errors  = 0;
    int period[NUM_CH];
    int cyc_g   = 0;

    typedef struct {
        logic [CH_W-1:0] winner;
        logic            tie;
        logic            timeout;
        int              cnt[NUM_CH];
        int              tol[NUM_CH];
    } exp_t;

    exp_t sb[$];

    ro_race_counter #(
        .NUM_CH (NUM_CH),
        .N      (N),
        .WIN_W  (WIN_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ro_in   (ro_in),
        .start   (start),
        .mode    (mode),
        .window  (window),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .winner  (winner),
        .tie     (tie),
        .timeout (timeout),
        .counts  (counts)
    );

    always #5 clk = ~clk;

    // Square-wave RO model from a shared cycle count: equal periods give identical taps.
    initial begin
        forever begin
            @(negedge clk);
            cyc_g++;
            for (int i = 0; i < NUM_CH; i++) begin
                ro_in[i] = (period[i] != 0) && ((cyc_g % period[i]) < (period[i] / 2));
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        vectors++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},    32'(busy),    0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_winner"},  32'(winner),  0);
        check({tag, "_tie"},     32'(tie),     0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_counts"},  32'(counts),  0);
    endtask

    function automatic exp_t mk(input int w, input bit t, input bit to,
                                input int c0, input int t0, input int c1, input int t1,
                                input int c2, input int t2, input int c3, input int t3);
        exp_t e;
        e.winner  = CH_W'(w);
        e.tie     = t;
        e.timeout = to;
        e.cnt[0] = c0; e.tol[0] = t0;
        e.cnt[1] = c1; e.tol[1] = t1;
        e.cnt[2] = c2; e.tol[2] = t2;
        e.cnt[3] = c3; e.tol[3] = t3;
        return e;
    endfunction

    task automatic set_ro(input int p0, input int p1, input int p2, input int p3);
        period[0] = p0; period[1] = p1; period[2] = p2; period[3] = p3;
    endtask

    // One measurement: push expectation, pulse start, wait for done, compare, ack.
    task automatic run(input string tag, input logic m, input int win, input exp_t e,
                       input int exp_busy, input int hold, input bit poke, input bit ack_start);
        exp_t got;
        int   busy_cyc;
        int   cyc;
        sb.push_back(e);
        @(negedge clk);
        mode   = m;
        window = WIN_W'(win);
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        cyc      = 0;
        while ((done !== 1'b1) && (cyc < 3000)) begin
            if (busy === 1'b1) busy_cyc++;
            start = poke && (cyc == 10);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 1);
        got = sb.pop_front();
        if (exp_busy >= 0) check({tag, "_busylen"}, 32'(busy_cyc), 32'(exp_busy));
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_done"},   32'(done),    1);
            check({tag, "_hold_winner"}, 32'(winner),  32'(got.winner));
            check({tag, "_hold_tie"},    32'(tie),     32'(got.tie));
        end
        check({tag, "_winner"},  32'(winner),  32'(got.winner));
        check({tag, "_tie"},     32'(tie),     32'(got.tie));
        check({tag, "_timeout"}, 32'(timeout), 32'(got.timeout));
        for (int i = 0; i < NUM_CH; i++) begin
            check_tol($sformatf("%s_cnt%0d", tag, i), int'(counts[i*N +: N]), got.cnt[i], got.tol[i]);
        end
        ack   = 1'b1;
        start = ack_start;
        @(negedge clk);
        ack   = 1'b0;
        start = 1'b0;
        check({tag, "_done_clr"},    32'(done),    0);
        check({tag, "_tie_clr"},     32'(tie),     0);
        check({tag, "_timeout_clr"}, 32'(timeout), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_idle_busy"}, 32'(busy), 0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        set_ro(10, 10, 4, 10);
        run("race", 1'b0, 1000, mk(2, 0, 0, 13, 3, 13, 3, 32, 0, 13, 3), -1, 0, 0, 0);

        set_ro(10, 4, 10, 4);
        run("race_tie", 1'b0, 1000, mk(1, 1, 0, 13, 3, 32, 0, 13, 3, 32, 0), -1, 0, 0, 0);

        set_ro(5, 4, 0, 0);
        run("window", 1'b1, 100, mk(1, 0, 0, 20, 1, 25, 1, 0, 0, 0, 0), 102, 0, 1, 0);

        set_ro(0, 0, 0, 0);
        run("race_tmo", 1'b0, 50, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 52, 20, 0, 0);

        run("win_static_w0", 1'b1, 0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 3, 0, 0, 1);

        set_ro(4, 3, 0, 0);
        run("win_sat", 1'b1, 200, mk(1, 0, 0, 50, 1, 63, 0, 0, 0, 0, 0), 202, 0, 0, 0);

        // Abort mid-COUNT with reset, then a clean window run.
        set_ro(5, 4, 0, 0);
        @(negedge clk);
        mode   = 1'b1;
        window = WIN_W'(100);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_busy_pre", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_zero("abort_rst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        run("after_rst", 1'b1, 100, mk(1, 0, 0, 20, 1, 25, 1, 0, 0, 0, 0), 102, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire
